// File: rtl/decoder_pkg.sv
// Shared types, widths and the 3->8 one-hot helper for the decoder family.
package decoder_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

  // Bit k set for code k.
  function automatic logic [OUT_W-1:0] onehot3(input logic [CODE_W-1:0] code);
    return OUT_W'(1) << code;
  endfunction

endpackage

// File: rtl/three_to_eight_decoder_comb.sv
// Pure combinational 3->8 one-hot decode.
//   code : binary code in
//   y_oh : one-hot out, bit k set for code k
module three_to_eight_decoder_comb
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [OUT_W-1:0]  y_oh
);

  assign y_oh = onehot3(code);

endmodule

// File: rtl/three_to_eight_decoder_seq.sv
// Registered 3->8 one-hot decoder with valid/ready handshake and a sweep mode
// that walks all eight codes in order.
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready, code : code input handshake
//   sweep_start             : start a sweep (IDLE only)
//   out_valid/out_ready     : result handshake
//   y_oh, y                 : one-hot result, and its optionally inverted copy
//   busy, sweep_done        : sweep in progress / final sweep code accepted
module three_to_eight_decoder_seq
  import decoder_pkg::*;
#(
  parameter bit SWEEP_DESC     = 1'b1,
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code,
  input  logic              sweep_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  y_oh,
  output logic [OUT_W-1:0]  y,
  output logic              busy,
  output logic              sweep_done
);

  localparam logic [CODE_W-1:0] SWEEP_FIRST = SWEEP_DESC ? CODE_W'(7) : CODE_W'(0);
  localparam logic [CODE_W-1:0] SWEEP_LAST  = SWEEP_DESC ? CODE_W'(0) : CODE_W'(7);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]  y_oh_q, y_oh_d;
  logic [OUT_W-1:0]  y_q, y_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;
  logic [OUT_W-1:0]  code_oh;

  // Input-path decode.
  three_to_eight_decoder_comb u_dec (
    .code (code),
    .y_oh (code_oh)
  );

  // Pass-through ready in HOLD so a stream of codes runs without bubbles.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    y_oh_d       = y_oh_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    sweep_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // in_valid has priority over sweep_start.
        if (in_valid) begin
          state_d     = ST_HOLD;
          y_oh_d      = code_oh;
          out_valid_d = 1'b1;
        end else if (sweep_start) begin
          state_d     = ST_SWEEP;
          cnt_d       = SWEEP_FIRST;
          y_oh_d      = onehot3(SWEEP_FIRST);
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          if (in_valid) begin
            y_oh_d = code_oh;
          end else begin
            state_d     = ST_IDLE;
            y_oh_d      = '0;
            out_valid_d = 1'b0;
          end
        end
      end

      ST_SWEEP: begin
        if (out_ready) begin
          if (cnt_q == SWEEP_LAST) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            y_oh_d       = '0;
            out_valid_d  = 1'b0;
            busy_d       = 1'b0;
            sweep_done_d = 1'b1;
          end else begin
            cnt_d  = SWEEP_DESC ? (cnt_q - CODE_W'(1)) : (cnt_q + CODE_W'(1));
            y_oh_d = onehot3(cnt_d);
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        y_oh_d       = '0;
        out_valid_d  = 1'b0;
        busy_d       = 1'b0;
      end
    endcase

    y_d = ACTIVE_LOW_OUT ? ~y_oh_d : y_oh_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      y_oh_q       <= '0;
      y_q          <= ACTIVE_LOW_OUT ? '1 : '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      y_oh_q       <= y_oh_d;
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign y_oh       = y_oh_q;
  assign y          = y_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_three_to_eight_decoder_seq.sv
// Directed bench for three_to_eight_decoder_seq (SWEEP_DESC=1, ACTIVE_LOW_OUT=0).
module tb_three_to_eight_decoder_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic       sweep_start;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y_oh;
  logic [7:0] y;
  logic       busy;
  logic       sweep_done;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  three_to_eight_decoder_seq #(
    .SWEEP_DESC     (1'b1),
    .ACTIVE_LOW_OUT (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .code        (code),
    .sweep_start (sweep_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y_oh        (y_oh),
    .y           (y),
    .busy        (busy),
    .sweep_done  (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference 8-to-3 priority encoder (highest set bit wins).
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  initial begin
    logic [7:0] exp_oh;
    int         idx;
    int         guard;
    int         done_cnt;

    rst_n = 1'b0; in_valid = 1'b0; code = 3'd0; sweep_start = 1'b0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_y_oh", y_oh, 8'h00);
    chk("rst_y", y, 8'h00);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_sweep_done", 8'(sweep_done), 8'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 8'(in_ready), 8'd1);

    // Single decode
    in_valid = 1'b1; code = 3'd5; out_ready = 1'b1;
    tick();
    chk("single_y_oh", y_oh, 8'b0010_0000);
    chk("single_y", y, 8'b0010_0000);
    chk("single_valid", 8'(out_valid), 8'd1);
    in_valid = 1'b0;
    tick();
    chk("single_idle_y_oh", y_oh, 8'h00);
    chk("single_idle_valid", 8'(out_valid), 8'd0);

    // Back-pressure
    in_valid = 1'b1; code = 3'd2; out_ready = 1'b0;
    tick();
    chk("bp_first", y_oh, 8'b0000_0100);
    for (int i = 0; i < 4; i++) begin
      code = 3'(i + 4);
      #1;
      chk("bp_in_ready", 8'(in_ready), 8'd0);
      tick();
      chk("bp_hold", y_oh, 8'b0000_0100);
      chk("bp_valid", 8'(out_valid), 8'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 8'(in_ready), 8'd1);
    tick();
    chk("bp_done_valid", 8'(out_valid), 8'd0);
    chk("bp_done_y_oh", y_oh, 8'h00);

    // Streaming 0..7, no bubbles
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; code = 3'(k); out_ready = 1'b1;
      tick();
      exp_oh = 8'h01 << k;
      chk("stream_y_oh", y_oh, exp_oh);
      chk("stream_valid", 8'(out_valid), 8'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 8'(out_valid), 8'd0);

    // Sweep, out_ready held high
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0; out_ready = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      exp_oh = 8'h80 >> i;
      chk("sweep_y_oh", y_oh, exp_oh);
      chk("sweep_busy", 8'(busy), 8'd1);
      chk("sweep_in_ready", 8'(in_ready), 8'd0);
      if (sweep_done) done_cnt++;
      tick();
    end
    chk("sweep_end_valid", 8'(out_valid), 8'd0);
    chk("sweep_end_busy", 8'(busy), 8'd0);
    chk("sweep_done_pulse", 8'(sweep_done), 8'd1);
    tick();
    chk("sweep_done_drop", 8'(sweep_done), 8'd0);
    chk("sweep_done_once", 8'(done_cnt), 8'd0);

    // Sweep with random stalls
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    idx = 0; guard = 0;
    while (idx < 8 && guard < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      exp_oh = 8'h80 >> idx;
      chk("stall_y_oh", y_oh, exp_oh);
      chk("stall_busy", 8'(busy), 8'd1);
      tick();
      if (out_ready) idx++;
      guard++;
    end
    chk("stall_completed", 8'(idx), 8'd8);
    chk("stall_done_pulse", 8'(sweep_done), 8'd1);
    chk("stall_end_valid", 8'(out_valid), 8'd0);
    out_ready = 1'b1;
    tick();

    // Simultaneous in_valid and sweep_start: decode wins
    in_valid = 1'b1; code = 3'd3; sweep_start = 1'b1; out_ready = 1'b0;
    tick();
    chk("simul_y_oh", y_oh, 8'h08);
    chk("simul_busy", 8'(busy), 8'd0);
    in_valid = 1'b0; sweep_start = 1'b0; out_ready = 1'b1;
    tick();
    chk("simul_end_valid", 8'(out_valid), 8'd0);
    chk("simul_end_busy", 8'(busy), 8'd0);

    // Reset mid-sweep at code 4
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    chk("midrst_at4", y_oh, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_y_oh", y_oh, 8'h00);
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_valid", 8'(out_valid), 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("midrst_no_done", 8'(sweep_done), 8'd0);
    chk("midrst_in_ready", 8'(in_ready), 8'd1);
    chk("midrst_post_busy", 8'(busy), 8'd0);

    // Loopback through the priority encoder
    for (int k = 0; k < 8; k++) begin
      exp_oh = 8'h01 << k;
      in_valid = 1'b1; code = prio_enc(exp_oh); out_ready = 1'b1;
      tick();
      chk("loop_y_oh", y_oh, exp_oh);
    end
    in_valid = 1'b0;
    tick();
    chk("loop_end_valid", 8'(out_valid), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
